// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(N) layers of 2:1 selection (amounts N/2 down to 1)
// spread over STAGES register boundaries, with a valid/ready handshake and a global stall.
// Optional feature: define PIPELINED_SHIFTER_ROTATE_EN to make ROL/ROR legal and build the
// wrap-around datapath; without it ops 011/100 are reported as illegal.
// N must be a power of two in 4..64 and STAGES must lie in 1..log2(N).
module pipelined_shifter #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_zero,
  output logic                 out_illegal
);

  localparam int unsigned Lw = $clog2(N);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;
`endif

  // Layer k (0 = largest amount) belongs to stage (k * STAGES) / Lw, so with STAGES == Lw
  // every layer gets its own register.
  function automatic int stage_of(input int layer);
    return (layer * int'(STAGES)) / int'(Lw);
  endfunction

  // One 2:1 selection layer: shift by a fixed amount sh according to op.
  function automatic logic [N-1:0] shift_layer(input logic [N-1:0] x, input logic [2:0] op,
                                               input int unsigned sh);
    logic [N-1:0] r;
    r = x;
    case (op)
      OpSll:   r = x << sh;
      OpSrl:   r = x >> sh;
      OpSra:   r = $signed(x) >>> sh;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      OpRol:   r = (x << sh) | (x >> (N - sh));
      OpRor:   r = (x >> sh) | (x << (N - sh));
`endif
      default: r = x;
    endcase
    return r;
  endfunction

  logic op_illegal;
  logic stall;
  logic accept;

  // Per-stage registered payload.
  logic [N-1:0]  data_q  [STAGES];
  logic [Lw-1:0] amt_q   [STAGES];
  logic [2:0]    op_q    [STAGES];
  logic          ill_q   [STAGES];
  logic          valid_q [STAGES];
  logic          zero_q;

  // Per-stage inputs and next-state data.
  logic [N-1:0]  src_data [STAGES];
  logic [Lw-1:0] src_amt  [STAGES];
  logic [2:0]    src_op   [STAGES];
  logic          src_ill  [STAGES];
  logic          src_vld  [STAGES];
  logic [N-1:0]  data_d   [STAGES];

`ifdef PIPELINED_SHIFTER_ROTATE_EN
  assign op_illegal = (in_op > OpRor);
`else
  assign op_illegal = (in_op > OpSra);
`endif

  // Reset overrides stall so in_ready reads 1 while rst is high.
  assign stall    = valid_q[STAGES-1] & ~out_ready & ~rst;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~rst;

  // Stage inputs and the combinational layers owned by each stage.
  always_comb begin
    // Illegal beats enter as zero data with a harmless op, so every layer yields zero.
    src_data[0] = op_illegal ? '0 : in_data;
    src_amt[0]  = in_amt;
    src_op[0]   = op_illegal ? OpSll : in_op;
    src_ill[0]  = op_illegal;
    src_vld[0]  = accept;
    for (int s = 1; s < STAGES; s++) begin
      src_data[s] = data_q[s-1];
      src_amt[s]  = amt_q[s-1];
      src_op[s]   = op_q[s-1];
      src_ill[s]  = ill_q[s-1];
      src_vld[s]  = valid_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = src_data[s];
      for (int k = 0; k < Lw; k++) begin
        if (stage_of(k) == s && src_amt[s][Lw-1-k]) begin
          data_d[s] = shift_layer(data_d[s], src_op[s], N >> (k + 1));
        end
      end
    end
  end

  // Pipeline registers: clear on reset, freeze on stall, payload loads only with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        amt_q[s]   <= '0;
        op_q[s]    <= '0;
        ill_q[s]   <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= src_vld[s];
        if (src_vld[s]) begin
          data_q[s] <= data_d[s];
          amt_q[s]  <= src_amt[s];
          op_q[s]   <= src_op[s];
          ill_q[s]  <= src_ill[s];
        end
      end
      if (src_vld[STAGES-1]) begin
        zero_q <= ~|data_d[STAGES-1];
      end
    end
  end

  // The final stage's amount and op are carried for uniformity but never consumed.
  logic unused_tail;
  assign unused_tail = ^{amt_q[STAGES-1], op_q[STAGES-1]};

  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign out_zero    = zero_q;
  assign out_illegal = ill_q[STAGES-1];

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter N, default 32, data width; SHALL be a power of two, 4 to 64.
REQ-002 Parameter STAGES, default 2, pipeline register count; SHALL be 1 to log2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-007 in_data  input  N  operand.
REQ-008 in_amt  input  log2(N)  shift amount, 0 to N-1.
REQ-009 in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  N  shifted result.
REQ-013 out_zero  output  1  out_data equals zero.
REQ-014 out_illegal  output  1  request carried an illegal op.

Function
REQ-015 Shifting SHALL use log2(N) layers of 2:1 selection, with amounts N/2 down to 1, split across STAGES register boundaries; the final register drives the outputs.
REQ-016 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready stays high.
REQ-017 Throughput SHALL be one request per cycle with no bubbles while out_ready stays high.
REQ-018 Stall: stall = out_valid & ~out_ready; while stall is high, every pipeline register SHALL hold, including its valid bit.
REQ-019 in_ready SHALL equal ~stall, combinationally.
REQ-020 A beat SHALL be accepted only when in_valid & in_ready; the register of any empty stage SHALL load a valid bit of 0.
REQ-021 out_data, out_zero and out_illegal SHALL stay stable while out_valid & ~out_ready.
REQ-022 SLL SHALL zero-fill the LSBs, and SRL SHALL zero-fill the MSBs.
REQ-023 SRA SHALL fill the MSBs with in_data[N-1].
REQ-024 ROL and ROR SHALL rotate, wrapping the bits that exit one end into the other end.
REQ-025 An amount of 0 SHALL pass in_data unchanged for every legal op.
REQ-026 An illegal op SHALL produce out_data of 0 and out_illegal of 1, and the beat SHALL still occupy one pipeline slot.
REQ-027 out_zero SHALL be computed from the final out_data, including the illegal-op case.
REQ-028 When STAGES equals log2(N), every layer SHALL be registered.

Reset
REQ-029 When rst is high at a clock edge, every stage valid bit SHALL clear, so out_valid is 0 the next cycle.
REQ-030 After reset, out_data, out_zero and out_illegal SHALL read 0.
REQ-031 Beats in flight at reset SHALL be discarded, and none SHALL emerge afterwards.
REQ-032 While rst is high, in_ready SHALL be 1, but no beat SHALL be captured.

Configuration
REQ-033 Macro PIPELINED_SHIFTER_ROTATE_EN: when defined, ROL and ROR are legal and include the wrap-around datapath.
REQ-034 When PIPELINED_SHIFTER_ROTATE_EN is undefined, the rotate datapath SHALL be absent, and ops 011 and 100 SHALL be treated as illegal per REQ-026.

Verification (N=32, STAGES=2, macro defined unless stated)
REQ-035 SLL, in_data 0x00000001, amt 31 -> out_data 0x80000000 two cycles later; then SRA, in_data 0x80000000, amt 4 -> 0xF8000000.
REQ-036 ROR, in_data 0x000000F1, amt 4 -> 0x1000000F; ROL, in_data 0x80000001, amt 1 -> 0x00000003; SRL, in_data 0x80000000, amt 31 -> 0x00000001, out_zero 0.
REQ-037 Back-to-back beats A, B, C with out_ready held low from the cycle A reaches the output for 3 cycles -> out_data holds A, in_ready is 0, and A, B, C then emerge in order with no loss or duplication.
REQ-038 Op 111, or op 011 with the macro undefined -> out_data 0x00000000, out_illegal 1, out_zero 1, and the next legal beat is unaffected.
REQ-039 rst asserted for one cycle with two beats in flight -> out_valid 0 the next cycle and no stale beat emerges; a fresh SLL, in_data 0x1, amt 0 -> 0x00000001 after two cycles.
